rf_latch_access_ctrl: RTL and testbench
=======================================

# rf_latch_access_ctrl

Access controller placed directly upstream of the 2-write/2-read latch-based register file used for IOPMP entry storage. Adds valid/ready handshakes on both write ports and both read ports, and a hardware clear sweep after reset, since latch storage has no reset. Resolves write/write, read/write and held-response hazards so that requesters never see latch-timing artefacts. Read responses arrive one cycle after acceptance.

## Interface
- ADDR_WIDTH, 5, word address width (≥1); depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width
- INIT_VALUE, '0, DATA_WIDTH value written to every word by the clear sweep
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- For x ∈ {a,b}, write request: wr_x_valid_i in 1; wr_x_ready_o out 1; wr_x_addr_i in ADDR_WIDTH; wr_x_data_i in DATA_WIDTH
- For x ∈ {a,b}, read request: rd_x_req_valid_i in 1; rd_x_req_ready_o out 1; rd_x_addr_i in ADDR_WIDTH
- For x ∈ {a,b}, read response: rd_x_rsp_valid_o out 1; rd_x_rsp_ready_i in 1; rd_x_rsp_data_o out DATA_WIDTH (= rf_rdata_x_i)
- For x ∈ {a,b}, register-file side: rf_raddr_x_o out ADDR_WIDTH; rf_rdata_x_i in DATA_WIDTH; rf_waddr_x_o out ADDR_WIDTH; rf_wdata_x_o out DATA_WIDTH; rf_we_x_o out 1
- init_done_o  out  1  high once the clear sweep has completed

## Operation
- FSM states:
  - RST: reset state; held for 1 cycle after rst_n rises.
  - INIT: the clear sweep.
  - RUN: normal operation; terminal state.
  - Transitions: RST→INIT unconditionally; INIT→RUN when the sweep counter reaches its last pair.
- INIT:
  - A counter cnt of ADDR_WIDTH-1 bits starts at 0.
  - rf_we_a_o = rf_we_b_o = 1; rf_waddr_a_o = {cnt,0}; rf_waddr_b_o = {cnt,1}; both rf_wdata = INIT_VALUE.
  - cnt increments every cycle and wraps only on leaving INIT. Sweep length is 2**(ADDR_WIDTH-1) cycles.
  - For ADDR_WIDTH=1 the sweep is a single cycle.
- In RST and INIT, all *_ready_o = 0.
- In RUN:
  - init_done_o = 1 (registered, set on the INIT→RUN edge).
  - rf_we_x_o = wr_x_valid_i & wr_x_ready_o, with the exception below; rf_waddr/rf_wdata pass through from the request.
- Write/write collision (both accepted, same address):
  - Both are acknowledged.
  - rf_we_a_o is suppressed; port b's data is stored (b wins).
- Read accept: rd_x_req_ready_o = RUN & (!rd_x_rsp_valid_o | rd_x_rsp_ready_i).
- On accept, rf_raddr_x_o = rd_x_addr_i combinationally, and the address is captured in held_addr_x. Otherwise rf_raddr_x_o = held_addr_x. This keeps the register file's internal address register stable while a response is stalled.
- rd_x_rsp_valid_o is set the cycle after accept. It clears on rsp_ready with no new accept; a new accept in that cycle keeps it set (back-to-back, full throughput).
- Same-cycle read and write to the same address: write-first. The response carries the new data.
- Held-response protection: while rd_x_rsp_valid_o & !rd_x_rsp_ready_i, any write whose address equals held_addr_x gets wr_y_ready_o = 0 (for both y). Writes to other addresses proceed.
- Otherwise wr_x_ready_o = RUN.

## Timing
- Reset values: all ready = 0; rsp_valid = 0; rf_we = 0; rf_raddr = 0; rf_waddr = 0; rf_wdata = 0; held_addr = 0; init_done_o = 0; state = RST.
- Read latency: accept at cycle T → rsp_valid at T+1 with data; the response is stable until the handshake completes.
- Write visibility: write accepted at T is returned by any read accepted at T or later.
- Reset asserted mid-INIT or mid-RUN: immediate return to RST; pending responses are dropped; the sweep restarts from 0.
- No combinational path from rd_x_rsp_ready_i to rf_we_y_o other than the ready gating above.

## Structure
- Package rf_latch_pkg: fsm state enum (RST, INIT, RUN) and a localparam function for the sweep length.
- Sub-module rf_latch_rd_port, instantiated twice: read handshake, held_addr register, response valid, and the held-address compare output.
- Top level: FSM, sweep counter, write muxing, collision logic, ready combination.

## Test plan
- Sweep, AW=3, INIT_VALUE=32'hDEAD_BEEF → init_done_o rises 1+4 cycles after rst_n; reads of all 8 addresses return 32'hDEAD_BEEF; all ready = 0 before init_done_o.
- Dual write, both to addr 5 (a=32'h1111, b=32'h2222) → both acked, rf_we_a_o = 0; read of 5 returns 32'h2222.
- Same cycle: write 32'hCAFE to addr 3 and read addr 3 on port a → response at T+1 = 32'hCAFE.
- Hold rd_a_rsp_ready_i = 0 for 4 cycles on a response for addr 7:
  - data stays constant;
  - a write to 7 sees ready = 0;
  - a write to 6 is accepted;
  - after release, the write to 7 completes and a re-read returns the new value.
- Streaming reads on both ports, 16 back-to-back with rsp_ready = 1 → one response per cycle, in order, correct data.
- Reset asserted at sweep cycle 2, with a request pending → outputs return to reset values; full sweep re-runs; init_done_o only after the full sweep.

Source files
------------

// File: rtl/rf_latch_pkg.sv
// Shared types and helpers for the latch register-file access controller.
package rf_latch_pkg;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Number of clear-sweep cycles: two words are written per cycle.
  function automatic int unsigned sweep_len(input int unsigned addr_width);
    return 32'd1 << (addr_width - 1);
  endfunction

endpackage

// File: rtl/rf_latch_rd_port.sv
// One read port: request handshake, held address, response valid, held-address compare.
module rf_latch_rd_port
  import rf_latch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b_i,
  output logic                  wr_hit_a_o,
  output logic                  wr_hit_b_o
);

  logic [ADDR_WIDTH-1:0] held_addr_q, held_addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  accept;
  logic                  stalled;

  always_comb begin
    req_ready_o = run_i & (~rsp_valid_q | rsp_ready_i);
    accept      = req_valid_i & req_ready_o;
    // Keep the RF address register stable unless a new request is taken.
    raddr_o     = accept ? addr_i : held_addr_q;
    held_addr_d = raddr_o;
    rsp_valid_d = accept | (rsp_valid_q & ~rsp_ready_i);
    stalled     = rsp_valid_q & ~rsp_ready_i;
    wr_hit_a_o  = stalled & (wr_addr_a_i == held_addr_q);
    wr_hit_b_o  = stalled & (wr_addr_b_i == held_addr_q);
    rsp_valid_o = rsp_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_addr_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      held_addr_q <= held_addr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: rtl/rf_latch_access_ctrl.sv
// Handshaking and hazard control in front of a 2W/2R latch register file,
// including a post-reset clear sweep of every word.
module rf_latch_access_ctrl
  import rf_latch_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 5,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_a_valid_i,
  output logic                  wr_a_ready_o,
  input  logic [ADDR_WIDTH-1:0] wr_a_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_a_data_i,
  input  logic                  wr_b_valid_i,
  output logic                  wr_b_ready_o,
  input  logic [ADDR_WIDTH-1:0] wr_b_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_b_data_i,
  input  logic                  rd_a_req_valid_i,
  output logic                  rd_a_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_a_addr_i,
  input  logic                  rd_b_req_valid_i,
  output logic                  rd_b_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_b_addr_i,
  output logic                  rd_a_rsp_valid_o,
  input  logic                  rd_a_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rd_a_rsp_data_o,
  output logic                  rd_b_rsp_valid_o,
  input  logic                  rd_b_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rd_b_rsp_data_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_a_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
  output logic [ADDR_WIDTH-1:0] rf_waddr_a_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_a_o,
  output logic                  rf_we_a_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_b_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
  output logic [ADDR_WIDTH-1:0] rf_waddr_b_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_b_o,
  output logic                  rf_we_b_o,
  output logic                  init_done_o
);

  // A one-bit counter is kept for ADDR_WIDTH=1; it never leaves zero.
  localparam int unsigned     CNT_W     = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam int unsigned     SWEEP_LEN = sweep_len(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWEEP_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_done_q, init_done_d;
  logic             run;
  logic             hit_aa, hit_ab, hit_ba, hit_bb;
  logic             acc_a, acc_b, collide;

  assign run = (state_q == RUN);

  rf_latch_rd_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run),
    .req_valid_i (rd_a_req_valid_i),
    .req_ready_o (rd_a_req_ready_o),
    .addr_i      (rd_a_addr_i),
    .rsp_valid_o (rd_a_rsp_valid_o),
    .rsp_ready_i (rd_a_rsp_ready_i),
    .raddr_o     (rf_raddr_a_o),
    .wr_addr_a_i (wr_a_addr_i),
    .wr_addr_b_i (wr_b_addr_i),
    .wr_hit_a_o  (hit_aa),
    .wr_hit_b_o  (hit_ab)
  );

  rf_latch_rd_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run),
    .req_valid_i (rd_b_req_valid_i),
    .req_ready_o (rd_b_req_ready_o),
    .addr_i      (rd_b_addr_i),
    .rsp_valid_o (rd_b_rsp_valid_o),
    .rsp_ready_i (rd_b_rsp_ready_i),
    .raddr_o     (rf_raddr_b_o),
    .wr_addr_a_i (wr_a_addr_i),
    .wr_addr_b_i (wr_b_addr_i),
    .wr_hit_a_o  (hit_ba),
    .wr_hit_b_o  (hit_bb)
  );

  assign rd_a_rsp_data_o = rf_rdata_a_i;
  assign rd_b_rsp_data_o = rf_rdata_b_i;
  assign init_done_o     = init_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      RST: begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      RUN: ;
      default: state_d = RST;
    endcase
  end

  always_comb begin
    wr_a_ready_o = run & ~(hit_aa | hit_ba);
    wr_b_ready_o = run & ~(hit_ab | hit_bb);
    acc_a        = wr_a_valid_i & wr_a_ready_o;
    acc_b        = wr_b_valid_i & wr_b_ready_o;
    // Same-address dual write: both acked, only port b reaches the latches.
    collide      = acc_a & acc_b & (wr_a_addr_i == wr_b_addr_i);
    rf_we_a_o    = 1'b0;
    rf_we_b_o    = 1'b0;
    rf_waddr_a_o = '0;
    rf_waddr_b_o = '0;
    rf_wdata_a_o = '0;
    rf_wdata_b_o = '0;
    if (state_q == INIT) begin
      rf_we_a_o    = 1'b1;
      rf_we_b_o    = 1'b1;
      rf_waddr_a_o = ADDR_WIDTH'({cnt_q, 1'b0});
      rf_waddr_b_o = ADDR_WIDTH'({cnt_q, 1'b1});
      rf_wdata_a_o = INIT_VALUE;
      rf_wdata_b_o = INIT_VALUE;
    end else if (run) begin
      rf_we_a_o    = acc_a & ~collide;
      rf_we_b_o    = acc_b;
      rf_waddr_a_o = wr_a_addr_i;
      rf_waddr_b_o = wr_b_addr_i;
      rf_wdata_a_o = wr_a_data_i;
      rf_wdata_b_o = wr_b_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

endmodule

// File: tb/tb_rf_latch_access_ctrl.sv
// Directed bench for rf_latch_access_ctrl with a behavioural 2W/2R latch RF model.
module tb_rf_latch_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_a_valid_i, wr_b_valid_i, wr_a_ready_o, wr_b_ready_o;
  logic [2:0]  wr_a_addr_i, wr_b_addr_i;
  logic [31:0] wr_a_data_i, wr_b_data_i;
  logic        rd_a_req_valid_i, rd_b_req_valid_i, rd_a_req_ready_o, rd_b_req_ready_o;
  logic [2:0]  rd_a_addr_i, rd_b_addr_i;
  logic        rd_a_rsp_valid_o, rd_b_rsp_valid_o, rd_a_rsp_ready_i, rd_b_rsp_ready_i;
  logic [31:0] rd_a_rsp_data_o, rd_b_rsp_data_o;
  logic [2:0]  rf_raddr_a_o, rf_raddr_b_o, rf_waddr_a_o, rf_waddr_b_o;
  logic [31:0] rf_rdata_a_i, rf_rdata_b_i, rf_wdata_a_o, rf_wdata_b_o;
  logic        rf_we_a_o, rf_we_b_o, init_done_o;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  rf_latch_access_ctrl #(
    .ADDR_WIDTH (3),
    .DATA_WIDTH (32),
    .INIT_VALUE (32'hDEAD_BEEF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_a_valid_i     (wr_a_valid_i),
    .wr_a_ready_o     (wr_a_ready_o),
    .wr_a_addr_i      (wr_a_addr_i),
    .wr_a_data_i      (wr_a_data_i),
    .wr_b_valid_i     (wr_b_valid_i),
    .wr_b_ready_o     (wr_b_ready_o),
    .wr_b_addr_i      (wr_b_addr_i),
    .wr_b_data_i      (wr_b_data_i),
    .rd_a_req_valid_i (rd_a_req_valid_i),
    .rd_a_req_ready_o (rd_a_req_ready_o),
    .rd_a_addr_i      (rd_a_addr_i),
    .rd_b_req_valid_i (rd_b_req_valid_i),
    .rd_b_req_ready_o (rd_b_req_ready_o),
    .rd_b_addr_i      (rd_b_addr_i),
    .rd_a_rsp_valid_o (rd_a_rsp_valid_o),
    .rd_a_rsp_ready_i (rd_a_rsp_ready_i),
    .rd_a_rsp_data_o  (rd_a_rsp_data_o),
    .rd_b_rsp_valid_o (rd_b_rsp_valid_o),
    .rd_b_rsp_ready_i (rd_b_rsp_ready_i),
    .rd_b_rsp_data_o  (rd_b_rsp_data_o),
    .rf_raddr_a_o     (rf_raddr_a_o),
    .rf_rdata_a_i     (rf_rdata_a_i),
    .rf_waddr_a_o     (rf_waddr_a_o),
    .rf_wdata_a_o     (rf_wdata_a_o),
    .rf_we_a_o        (rf_we_a_o),
    .rf_raddr_b_o     (rf_raddr_b_o),
    .rf_rdata_b_i     (rf_rdata_b_i),
    .rf_waddr_b_o     (rf_waddr_b_o),
    .rf_wdata_b_o     (rf_wdata_b_o),
    .rf_we_b_o        (rf_we_b_o),
    .init_done_o      (init_done_o)
  );

  // Latch RF model: registered read address, port b written last so it wins.
  logic [31:0] mem [8];
  logic [2:0]  raddr_a_q, raddr_b_q;
  always @(posedge clk) begin
    if (rf_we_a_o) mem[rf_waddr_a_o] <= rf_wdata_a_o;
    if (rf_we_b_o) mem[rf_waddr_b_o] <= rf_wdata_b_o;
    raddr_a_q <= rf_raddr_a_o;
    raddr_b_q <= rf_raddr_b_o;
  end
  assign rf_rdata_a_i = mem[raddr_a_q];
  assign rf_rdata_b_i = mem[raddr_b_q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_a_valid_i     = 1'b0;
    wr_b_valid_i     = 1'b0;
    rd_a_req_valid_i = 1'b0;
    rd_b_req_valid_i = 1'b0;
  endtask

  function automatic logic [3:0] rdy();
    return {wr_a_ready_o, wr_b_ready_o, rd_a_req_ready_o, rd_b_req_ready_o};
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    wr_a_addr_i = '0; wr_b_addr_i = '0; wr_a_data_i = '0; wr_b_data_i = '0;
    rd_a_addr_i = '0; rd_b_addr_i = '0;
    rd_a_rsp_ready_i = 1'b1; rd_b_rsp_ready_i = 1'b1;
    repeat (2) cycle();

    chk("rst_ready", {28'd0, rdy()}, 32'h0);
    chk("rst_rsp_valid", {30'd0, rd_a_rsp_valid_o, rd_b_rsp_valid_o}, 32'h0);
    chk("rst_we", {30'd0, rf_we_a_o, rf_we_b_o}, 32'h0);
    chk("rst_raddr", {26'd0, rf_raddr_a_o, rf_raddr_b_o}, 32'h0);
    chk("rst_waddr", {26'd0, rf_waddr_a_o, rf_waddr_b_o}, 32'h0);
    chk("rst_wdata_a", rf_wdata_a_o, 32'h0);
    chk("rst_wdata_b", rf_wdata_b_o, 32'h0);
    chk("rst_init_done", {31'd0, init_done_o}, 32'h0);

    // Sweep: one RST cycle, then four INIT cycles writing pairs.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("init_we", {30'd0, rf_we_a_o, rf_we_b_o}, 32'h3);
      chk("init_waddr_a", {29'd0, rf_waddr_a_o}, 32'(2 * i));
      chk("init_waddr_b", {29'd0, rf_waddr_b_o}, 32'(2 * i + 1));
      chk("init_wdata", rf_wdata_a_o, 32'hDEAD_BEEF);
      chk("init_ready", {28'd0, rdy()}, 32'h0);
      chk("init_done_low", {31'd0, init_done_o}, 32'h0);
    end
    cycle();
    chk("init_done_high", {31'd0, init_done_o}, 32'h1);
    chk("run_ready", {28'd0, rdy()}, 32'hF);

    for (int i = 0; i < 4; i++) begin
      rd_a_req_valid_i = 1'b1; rd_a_addr_i = 3'(i);
      rd_b_req_valid_i = 1'b1; rd_b_addr_i = 3'(i + 4);
      cycle();
      chk("sweep_rsp_valid", {30'd0, rd_a_rsp_valid_o, rd_b_rsp_valid_o}, 32'h3);
      chk("sweep_data_a", rd_a_rsp_data_o, 32'hDEAD_BEEF);
      chk("sweep_data_b", rd_b_rsp_data_o, 32'hDEAD_BEEF);
    end
    idle();
    cycle();
    chk("rsp_drain", {30'd0, rd_a_rsp_valid_o, rd_b_rsp_valid_o}, 32'h0);

    // Dual write to the same address: b wins, a's enable suppressed.
    wr_a_valid_i = 1'b1; wr_a_addr_i = 3'd5; wr_a_data_i = 32'h1111;
    wr_b_valid_i = 1'b1; wr_b_addr_i = 3'd5; wr_b_data_i = 32'h2222;
    #1;
    chk("ww_ready", {30'd0, wr_a_ready_o, wr_b_ready_o}, 32'h3);
    chk("ww_we", {30'd0, rf_we_a_o, rf_we_b_o}, 32'h1);
    cycle();
    idle();
    rd_a_req_valid_i = 1'b1; rd_a_addr_i = 3'd5;
    cycle();
    idle();
    chk("ww_read5", rd_a_rsp_data_o, 32'h2222);

    // Same-cycle write and read of address 3.
    wr_a_valid_i = 1'b1; wr_a_addr_i = 3'd3; wr_a_data_i = 32'hCAFE;
    rd_a_req_valid_i = 1'b1; rd_a_addr_i = 3'd3;
    #1;
    chk("rw_raddr", {29'd0, rf_raddr_a_o}, 32'h3);
    chk("rw_we_a", {31'd0, rf_we_a_o}, 32'h1);
    cycle();
    idle();
    chk("rw_rsp_valid", {31'd0, rd_a_rsp_valid_o}, 32'h1);
    chk("rw_data", rd_a_rsp_data_o, 32'hCAFE);
    cycle();

    // Held response on address 7 for four cycles.
    rd_a_rsp_ready_i = 1'b0;
    rd_a_req_valid_i = 1'b1; rd_a_addr_i = 3'd7;
    cycle();
    idle();
    chk("hold_first", rd_a_rsp_data_o, 32'hDEAD_BEEF);
    wr_a_valid_i = 1'b1; wr_a_addr_i = 3'd7; wr_a_data_i = 32'h7777;
    wr_b_valid_i = 1'b1; wr_b_addr_i = 3'd6; wr_b_data_i = 32'h6666;
    rd_a_req_valid_i = 1'b1; rd_a_addr_i = 3'd3;
    #1;
    chk("hold_wr_ready", {30'd0, wr_a_ready_o, wr_b_ready_o}, 32'h1);
    chk("hold_we", {30'd0, rf_we_a_o, rf_we_b_o}, 32'h1);
    chk("hold_rd_ready", {31'd0, rd_a_req_ready_o}, 32'h0);
    chk("hold_raddr", {29'd0, rf_raddr_a_o}, 32'h7);
    cycle();
    wr_b_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_data", rd_a_rsp_data_o, 32'hDEAD_BEEF);
      chk("hold_wr7_ready", {31'd0, wr_a_ready_o}, 32'h0);
      chk("hold_valid", {31'd0, rd_a_rsp_valid_o}, 32'h1);
      cycle();
    end
    rd_a_req_valid_i = 1'b0;
    rd_a_rsp_ready_i = 1'b1;
    #1;
    chk("release_wr_ready", {31'd0, wr_a_ready_o}, 32'h1);
    chk("release_we", {31'd0, rf_we_a_o}, 32'h1);
    cycle();
    idle();
    chk("release_valid", {31'd0, rd_a_rsp_valid_o}, 32'h0);
    rd_a_req_valid_i = 1'b1; rd_a_addr_i = 3'd7;
    rd_b_req_valid_i = 1'b1; rd_b_addr_i = 3'd6;
    cycle();
    idle();
    chk("reread7", rd_a_rsp_data_o, 32'h7777);
    chk("reread6", rd_b_rsp_data_o, 32'h6666);

    // Fill with 0x100+addr, then stream 16 reads per port.
    for (int i = 0; i < 4; i++) begin
      wr_a_valid_i = 1'b1; wr_a_addr_i = 3'(2 * i);     wr_a_data_i = 32'h100 + 32'(2 * i);
      wr_b_valid_i = 1'b1; wr_b_addr_i = 3'(2 * i + 1); wr_b_data_i = 32'h100 + 32'(2 * i + 1);
      cycle();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      rd_a_req_valid_i = 1'b1; rd_a_addr_i = 3'(i % 8);
      rd_b_req_valid_i = 1'b1; rd_b_addr_i = 3'(7 - (i % 8));
      #1;
      chk("stream_ready", {30'd0, rd_a_req_ready_o, rd_b_req_ready_o}, 32'h3);
      cycle();
      chk("stream_valid", {30'd0, rd_a_rsp_valid_o, rd_b_rsp_valid_o}, 32'h3);
      chk("stream_data_a", rd_a_rsp_data_o, 32'h100 + 32'(i % 8));
      chk("stream_data_b", rd_b_rsp_data_o, 32'h100 + 32'(7 - (i % 8)));
    end
    idle();
    cycle();
    chk("stream_drain", {30'd0, rd_a_rsp_valid_o, rd_b_rsp_valid_o}, 32'h0);

    // Reset with a stalled response, then again mid-sweep.
    rd_a_rsp_ready_i = 1'b0;
    rd_a_req_valid_i = 1'b1; rd_a_addr_i = 3'd1;
    cycle();
    idle();
    chk("pend_valid", {31'd0, rd_a_rsp_valid_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", {30'd0, rd_a_rsp_valid_o, rd_b_rsp_valid_o}, 32'h0);
    chk("rst2_ready", {28'd0, rdy()}, 32'h0);
    chk("rst2_init_done", {31'd0, init_done_o}, 32'h0);
    chk("rst2_raddr", {26'd0, rf_raddr_a_o, rf_raddr_b_o}, 32'h0);
    cycle();
    rst_n = 1'b1;
    rd_b_req_valid_i = 1'b1; rd_b_addr_i = 3'd4;
    cycle();
    chk("resweep0_waddr", {29'd0, rf_waddr_a_o}, 32'h0);
    cycle();
    cycle();
    chk("sweep2_waddr", {29'd0, rf_waddr_a_o}, 32'h4);
    chk("sweep2_we", {30'd0, rf_we_a_o, rf_we_b_o}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("rst3_we", {30'd0, rf_we_a_o, rf_we_b_o}, 32'h0);
    chk("rst3_waddr", {26'd0, rf_waddr_a_o, rf_waddr_b_o}, 32'h0);
    chk("rst3_ready", {28'd0, rdy()}, 32'h0);
    chk("rst3_init_done", {31'd0, init_done_o}, 32'h0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("resweep_waddr", {29'd0, rf_waddr_a_o}, 32'(2 * i));
      chk("resweep_init_done", {31'd0, init_done_o}, 32'h0);
      chk("resweep_ready", {28'd0, rdy()}, 32'h0);
    end
    cycle();
    chk("resweep_done", {31'd0, init_done_o}, 32'h1);
    chk("resweep_rd_b_ready", {31'd0, rd_b_req_ready_o}, 32'h1);
    cycle();
    idle();
    chk("post_rst_valid", {30'd0, rd_a_rsp_valid_o, rd_b_rsp_valid_o}, 32'h1);
    chk("post_rst_data_b", rd_b_rsp_data_o, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
